// File: rtl/adpll_loop_pkg.sv
// Shared types and defaults for the ADPLL loop-gain scheduler.
//   gear_t        : gain gear reported on gear_o
//   sched_state_t : scheduler FSM states
//   abs_sat()     : magnitude of a signed error. The most negative code
//                   saturates to the largest positive code.
package adpll_loop_pkg;

  localparam int ERROR_WIDTH = 8;
  localparam int KP_WIDTH    = 5;
  localparam int KI_WIDTH    = 11;

  typedef enum logic [1:0] {
    GEAR_ACQ = 2'd0,
    GEAR_TRK = 2'd1,
    GEAR_FIN = 2'd2
  } gear_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2,
    FINE  = 2'd3
  } sched_state_t;

  function automatic int abs_sat(input int err, input int width);
    int mag;
    int lim;
    lim = (1 << (width - 1)) - 1;
    mag = (err < 0) ? -err : err;
    if (mag > lim) mag = lim;
    return mag;
  endfunction

endpackage

// File: rtl/loop_gain_scheduler_run_counter.sv
// run_counter: saturating counter of consecutive events.
//   clk, reset : clock and synchronous active-high reset
//   inc        : one more event in the run
//   clr        : run broken; has priority over inc
//   done       : this cycle's inc brings the run to TARGET. The owner is
//                expected to assert clr in the same cycle to start a new run.
module run_counter #(
  parameter int TARGET = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam int W = $clog2(TARGET + 1);

  logic [W-1:0] count;

  assign done = inc && (count == W'(TARGET - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != W'(TARGET))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/loop_gain_scheduler.sv
// loop_gain_scheduler: selects the ADPLL loop filter gains through three
// gears. ACQ is wide, TRACK is medium and FINE is narrow. The block steps
// down one gear after a run of small phase errors. It falls back to ACQ
// after a run of large phase errors.
//   gen_clk_i, reset_i : clock and synchronous active-high reset
//   enable_i           : run; when low the block sits in IDLE with ACQ gains
//   force_reacq_i      : restart in ACQ
//   error_valid_i      : error_i holds a new sample
//   error_i            : signed phase error from the detector
//   kp_o, ki_o         : gains to the loop filter
//   gear_o             : 0 = ACQ/IDLE, 1 = TRACK, 2 = FINE
//   gear_change_o      : one-cycle pulse whenever gear_o changes
//   locked_o           : high while in FINE
//   timeout_o          : sticky ACQ timeout
// Optional feature: LOOP_GAIN_SCHED_TIMEOUT_EN adds an ACQ sample counter
// that drives timeout_o. When the macro is undefined, timeout_o is tied 0.
//
// state | meaning
// IDLE  | disabled, ACQ gains loaded, waiting for enable_i
// ACQ   | wide gains, counting good samples toward TRACK
// TRACK | medium gains, good run -> FINE, bad run -> ACQ
// FINE  | narrow gains, locked, bad run -> ACQ
module loop_gain_scheduler
  import adpll_loop_pkg::*;
#(
  parameter int ERROR_WIDTH   = adpll_loop_pkg::ERROR_WIDTH,
  parameter int KP_WIDTH      = adpll_loop_pkg::KP_WIDTH,
  parameter int KI_WIDTH      = adpll_loop_pkg::KI_WIDTH,
  parameter int KP_ACQ        = 8,
  parameter int KI_ACQ        = 16,
  parameter int KP_TRK        = 4,
  parameter int KI_TRK        = 4,
  parameter int KP_FIN        = 1,
  parameter int KI_FIN        = 1,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 16,
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_COUNT  = 2,
  parameter int ACQ_TIMEOUT   = 1024
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          force_reacq_i,
  input  logic                          error_valid_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic        [KP_WIDTH-1:0]    kp_o,
  output logic        [KI_WIDTH-1:0]    ki_o,
  output logic        [1:0]             gear_o,
  output logic                          gear_change_o,
  output logic                          locked_o,
  output logic                          timeout_o
);

  if (UNLOCK_THRESH <= LOCK_THRESH || LOCK_COUNT < 1 || UNLOCK_COUNT < 1 ||
      ACQ_TIMEOUT < 1) begin : g_bad_params
    $error("loop_gain_scheduler: inconsistent parameters");
  end

  localparam logic [KP_WIDTH-1:0] KP_A = KP_WIDTH'(KP_ACQ);
  localparam logic [KI_WIDTH-1:0] KI_A = KI_WIDTH'(KI_ACQ);
  localparam logic [KP_WIDTH-1:0] KP_T = KP_WIDTH'(KP_TRK);
  localparam logic [KI_WIDTH-1:0] KI_T = KI_WIDTH'(KI_TRK);
  localparam logic [KP_WIDTH-1:0] KP_F = KP_WIDTH'(KP_FIN);
  localparam logic [KI_WIDTH-1:0] KI_F = KI_WIDTH'(KI_FIN);

  sched_state_t            state;
  gear_t                   gear_q;
  logic [ERROR_WIDTH-1:0]  abs_err;
  logic                    is_good, is_bad, proc;
  logic                    good_en, bad_en;
  logic                    good_inc, good_clr, good_done;
  logic                    bad_inc, bad_clr, bad_done;
  logic                    tmo_hit;

  assign abs_err = ERROR_WIDTH'(abs_sat(int'(error_i), ERROR_WIDTH));
  assign is_good = abs_err <= ERROR_WIDTH'(LOCK_THRESH);
  assign is_bad  = abs_err >  ERROR_WIDTH'(UNLOCK_THRESH);

  // Samples are processed only when neither enable_i=0 nor force_reacq_i
  // overrides the cycle.
  assign proc    = enable_i && !force_reacq_i;
  assign good_en = (state == ACQ) || (state == TRACK);
  assign bad_en  = (state == TRACK) || (state == FINE);

  // A mid-range sample is neither good nor bad, so it breaks both runs.
  // Any gear move restarts both runs.
  assign good_inc = proc && good_en && error_valid_i && is_good;
  assign good_clr = !proc || !good_en || (error_valid_i && !is_good) ||
                    good_done || bad_done || tmo_hit;
  assign bad_inc  = proc && bad_en && error_valid_i && is_bad;
  assign bad_clr  = !proc || !bad_en || (error_valid_i && !is_bad) ||
                    good_done || bad_done;

  run_counter #(.TARGET(LOCK_COUNT)) u_good (
    .clk   (gen_clk_i),
    .reset (reset_i),
    .inc   (good_inc),
    .clr   (good_clr),
    .done  (good_done)
  );

  run_counter #(.TARGET(UNLOCK_COUNT)) u_bad (
    .clk   (gen_clk_i),
    .reset (reset_i),
    .inc   (bad_inc),
    .clr   (bad_clr),
    .done  (bad_done)
  );

`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);
  logic [TW-1:0] acq_cnt;
  logic          acq_inc;

  assign acq_inc = proc && (state == ACQ) && error_valid_i;
  // A gear step on the same sample wins over the timeout.
  assign tmo_hit = acq_inc && !good_done && (acq_cnt == TW'(ACQ_TIMEOUT - 1));

  always_ff @(posedge gen_clk_i) begin
    if (reset_i || !proc || (state != ACQ) || good_done || tmo_hit) begin
      acq_cnt <= '0;
    end else if (acq_inc) begin
      acq_cnt <= acq_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign gear_o = gear_q;

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      gear_q        <= GEAR_ACQ;
      kp_o          <= KP_A;
      ki_o          <= KI_A;
      gear_change_o <= 1'b0;
      locked_o      <= 1'b0;
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
      timeout_o     <= 1'b0;
`endif
    end else begin
      gear_change_o <= 1'b0;
      if (!enable_i || force_reacq_i) begin
        state         <= enable_i ? ACQ : IDLE;
        gear_q        <= GEAR_ACQ;
        kp_o          <= KP_A;
        ki_o          <= KI_A;
        locked_o      <= 1'b0;
        // Pulse only if the gear actually moves. A restart from IDLE or
        // from ACQ leaves the gear at 0.
        gear_change_o <= (gear_q != GEAR_ACQ);
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
        if (!enable_i) timeout_o <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: state <= ACQ;
          ACQ: begin
            if (good_done) begin
              state         <= TRACK;
              gear_q        <= GEAR_TRK;
              kp_o          <= KP_T;
              ki_o          <= KI_T;
              gear_change_o <= 1'b1;
`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
              timeout_o     <= 1'b0;
            end else if (tmo_hit) begin
              timeout_o     <= 1'b1;
`endif
            end
          end
          TRACK: begin
            if (good_done) begin
              state         <= FINE;
              gear_q        <= GEAR_FIN;
              kp_o          <= KP_F;
              ki_o          <= KI_F;
              gear_change_o <= 1'b1;
              locked_o      <= 1'b1;
            end else if (bad_done) begin
              state         <= ACQ;
              gear_q        <= GEAR_ACQ;
              kp_o          <= KP_A;
              ki_o          <= KI_A;
              gear_change_o <= 1'b1;
            end
          end
          FINE: begin
            if (bad_done) begin
              state         <= ACQ;
              gear_q        <= GEAR_ACQ;
              kp_o          <= KP_A;
              ki_o          <= KI_A;
              gear_change_o <= 1'b1;
              locked_o      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Self-checking bench for loop_gain_scheduler with default parameters.
// The bench compares every output on every cycle with a behavioural model
// of the gear rules. The directed scenarios come first. Random traffic
// follows.
// When LOOP_GAIN_SCHED_TIMEOUT_EN is defined, the DUT is built with
// ACQ_TIMEOUT=16.
module tb_loop_gain_scheduler;

`ifdef LOOP_GAIN_SCHED_TIMEOUT_EN
  localparam int ACQ_T  = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int ACQ_T  = 1024;
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, en, frc, vld;
  logic signed [7:0] err;
  logic [4:0]        kp;
  logic [10:0]       ki;
  logic [1:0]        gear;
  logic              gc, lk, to;

  always #5 clk = ~clk;

  loop_gain_scheduler #(.ACQ_TIMEOUT(ACQ_T)) dut (
    .gen_clk_i     (clk),
    .reset_i       (rst),
    .enable_i      (en),
    .force_reacq_i (frc),
    .error_valid_i (vld),
    .error_i       (err),
    .kp_o          (kp),
    .ki_o          (ki),
    .gear_o        (gear),
    .gear_change_o (gc),
    .locked_o      (lk),
    .timeout_o     (to)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "reset";

  // Model state: 0 idle, 1 acq, 2 track, 3 fine. The other fields are the
  // run lengths, the ACQ sample count and the output flags.
  int m_state, m_good, m_bad, m_acq, m_gc, m_to;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s_%s: got %0d, expected %0d (t=%0t)", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic int gear_of(input int s);
    return (s == 2) ? 1 : (s == 3) ? 2 : 0;
  endfunction

  function automatic int kp_of(input int g);
    return (g == 1) ? 4 : (g == 2) ? 1 : 8;
  endfunction

  function automatic int ki_of(input int g);
    return (g == 1) ? 4 : (g == 2) ? 1 : 16;
  endfunction

  task automatic model_clear();
    m_good = 0; m_bad = 0; m_acq = 0;
  endtask

  task automatic model_step(input bit e, input bit f, input bit v, input int x);
    int a, pg;
    a  = (x < 0) ? -x : x;
    if (a > 127) a = 127;
    pg = gear_of(m_state);
    if (!e) begin
      m_state = 0; model_clear(); m_to = 0;
    end else if (f) begin
      m_state = 1; model_clear();
    end else if (m_state == 0) begin
      m_state = 1; model_clear();
    end else if (v) begin
      m_good = (a <= 4 && m_state != 3) ? m_good + 1 : 0;
      m_bad  = (a > 16 && m_state != 1) ? m_bad + 1 : 0;
      if (m_state == 1) m_acq++;
      if (m_good == 8) begin
        m_state = m_state + 1; model_clear();
        if (m_state == 2) m_to = 0;
      end else if (m_bad == 2) begin
        m_state = 1; model_clear();
      end else if (TMO_EN && m_state == 1 && m_acq == ACQ_T) begin
        m_to = 1; m_acq = 0; m_good = 0;
      end
    end
    m_gc = (gear_of(m_state) != pg) ? 1 : 0;
  endtask

  task automatic check_all();
    int g;
    g = gear_of(m_state);
    chk("kp",     int'(kp),   kp_of(g));
    chk("ki",     int'(ki),   ki_of(g));
    chk("gear",   int'(gear), g);
    chk("gchg",   int'(gc),   m_gc);
    chk("locked", int'(lk),   (m_state == 3) ? 1 : 0);
    chk("tmo",    int'(to),   m_to);
  endtask

  task automatic drive(input bit e, input bit f, input bit v, input int x);
    en = e; frc = f; vld = v; err = 8'(x);
    @(posedge clk);
    model_step(e, f, v, x);
    #1;
    check_all();
  endtask

  task automatic samples(input int n, input int x);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; frc = 1'b0; vld = 1'b0; err = '0;
    m_state = 0; model_clear(); m_gc = 0; m_to = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    phase = "to_track";
    drive(1'b1, 1'b0, 1'b0, 0);
    samples(8, 3);
    phase = "to_fine";
    samples(8, -4);
    phase = "unlock";
    samples(2, 20);
    phase = "relock";
    samples(16, 0);
    phase = "fine_hold";
    samples(1, 20); samples(1, 10); samples(1, 20);

    phase = "track_break";
    drive(1'b1, 1'b1, 1'b0, 0);
    samples(8, 1);
    samples(7, 2); samples(1, 5); samples(7, -2);
    phase = "track_step";
    samples(1, 4);

    phase = "neg_sat";
    samples(2, -128);
    phase = "disable";
    samples(8, 0);
    drive(1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    phase = "force_8th";
    samples(7, 0);
    drive(1'b1, 1'b1, 1'b1, 0);
    samples(3, 0);

    phase = "acq_tmo";
    drive(1'b1, 1'b1, 1'b0, 0);
    samples(16, 30);
    samples(2, 0);

    phase = "random";
    begin
      bit mode;
      mode = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        int r, x;
        if ((c % 64) == 0) mode = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 9));
        if (r < (mode ? 9 : 5))  x = int'($urandom_range(0, 8)) - 4;
        else if (r < 7 || mode)  x = int'($urandom_range(5, 16));
        else if (r < 9)          x = int'($urandom_range(17, 127));
        else                     x = -128;
        if ($urandom_range(0, 1) == 1 && x > 0) x = -x;
        drive(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 47) == 0),
              1'($urandom_range(0, 3) != 0), x);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
